// File: rtl/dvp_pkg.sv
// dvp_pkg: shared types and constants for the DVP transmit block.
//   dvp_tx_state_t : frame-timing FSM states
//   BAR_*          : the eight RGB565 colour-bar values, left to right
//   bar_color()    : bar index -> RGB565 colour
//   max_of()       : elaboration-time helper for counter sizing
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } dvp_tx_state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = BAR_WHITE;
            3'd1:    bar_color = BAR_YELLOW;
            3'd2:    bar_color = BAR_CYAN;
            3'd3:    bar_color = BAR_GREEN;
            3'd4:    bar_color = BAR_MAGENTA;
            3'd5:    bar_color = BAR_RED;
            3'd6:    bar_color = BAR_BLUE;
            3'd7:    bar_color = BAR_BLACK;
            default: bar_color = BAR_BLACK;
        endcase
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_tx_pattern.sv
// dvp_tx_pattern: colour-bar pixel source, one pixel per fetch.
//   ov5640_pclk, s_rst_n : clock, async active-low reset
//   fetch                : a pixel is consumed this cycle
//   line_start           : this fetch is the first pixel of a line
//   color                : RGB565 colour of the pixel consumed this cycle
module dvp_tx_pattern
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic        ov5640_pclk,
    input  logic        s_rst_n,
    input  logic        fetch,
    input  logic        line_start,
    output logic [15:0] color
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAR_W - 1);

    logic [2:0]    bar_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bar_cur_s;
    logic [CW-1:0] cnt_cur_s;

    // The first fetch of a line restarts at bar 0 regardless of where the last line stopped.
    always_comb begin
        bar_cur_s = bar_r;
        cnt_cur_s = cnt_r;
        if (line_start) begin
            bar_cur_s = 3'd0;
            cnt_cur_s = '0;
        end else begin
            bar_cur_s = bar_r;
            cnt_cur_s = cnt_r;
        end
    end

    assign color = bar_color(bar_cur_s);

    // Advance the position within the bar (and the bar index) after each consumed pixel.
    always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            bar_r <= 3'd0;
            cnt_r <= '0;
        end else if (fetch) begin
            if (cnt_cur_s == CNT_LAST) begin
                bar_r <= bar_cur_s + 3'd1;
                cnt_r <= '0;
            end else begin
                bar_r <= bar_cur_s;
                cnt_r <= cnt_cur_s + CW'(1);
            end
        end else begin
            bar_r <= bar_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/dvp_tx.sv
// dvp_tx: DVP (camera byte interface) source. Emits vsync/href/data timing for
// one frame per start, RGB565 pixels serialised high byte first.
// Ports:
//   ov5640_pclk, s_rst_n     : clock, async active-low reset
//   enable                   : run frames back to back while high
//   pattern_sel              : 1 = internal colour bars (only with DVP_TX_PATTERN_EN)
//   s_data/s_valid/s_ready   : upstream pixel stream
//   ov5640_vsync/href/data   : DVP bus
//   frame_done               : pulse on the last cycle of a frame
//   underrun                 : sticky, a pixel was missing in the current frame
// Build option: define DVP_TX_PATTERN_EN to include the colour-bar generator.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 144,
    parameter int VSYNC_LEN = 16,
    parameter int V_BACK    = 400,
    parameter int V_FRONT   = 400
) (
    input  logic        ov5640_pclk,
    input  logic        s_rst_n,
    input  logic        enable,
    input  logic        pattern_sel,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        ov5640_vsync,
    output logic        ov5640_href,
    output logic [7:0]  ov5640_data,
    output logic        frame_done,
    output logic        underrun
);

    localparam int MAX_PH = max_of(max_of(max_of(VSYNC_LEN, V_BACK), max_of(2 * H_ACTIVE, H_BLANK)), V_FRONT);
    localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
    localparam int LN_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [PH_W-1:0] VS_LAST  = PH_W'(VSYNC_LEN - 1);
    localparam logic [PH_W-1:0] VB_LAST  = PH_W'(V_BACK - 1);
    localparam logic [PH_W-1:0] ACT_LAST = PH_W'(2 * H_ACTIVE - 1);
    localparam logic [PH_W-1:0] HB_LAST  = PH_W'(H_BLANK - 1);
    localparam logic [PH_W-1:0] VF_LAST  = PH_W'(V_FRONT - 1);
    localparam logic [LN_W-1:0] LN_LAST  = LN_W'(V_ACTIVE - 1);

    dvp_tx_state_t   state_r, state_nxt_s;
    logic [PH_W-1:0] phase_r, phase_nxt_s;
    logic [LN_W-1:0] line_r, line_nxt_s;
    logic            byte_r, byte_nxt_s;
    logic            fetch_r, fetch_nxt_s;
    logic            pat_r;
    logic            pattern_sel_s;
    logic [15:0]     pat_color_s;
    logic [15:0]     pixel_s;
    logic [7:0]      low_r;

`ifdef DVP_TX_PATTERN_EN
    logic line_start_s;

    assign pattern_sel_s = pattern_sel;
    // A fetch outside ACTIVE is always the first pixel of a line.
    assign line_start_s  = fetch_r && (state_r != ST_ACTIVE);

    dvp_tx_pattern #(.H_ACTIVE(H_ACTIVE)) u_pattern (
        .ov5640_pclk (ov5640_pclk),
        .s_rst_n     (s_rst_n),
        .fetch       (fetch_r),
        .line_start  (line_start_s),
        .color       (pat_color_s)
    );
`else
    logic unused_pattern_sel_s;

    assign unused_pattern_sel_s = pattern_sel;
    assign pattern_sel_s        = 1'b0;
    assign pat_color_s          = 16'h0000;
`endif

    // Next-state, counter and fetch-slot decode; outputs are registered from these.
    always_comb begin
        state_nxt_s = state_r;
        line_nxt_s  = line_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_VSYNC;
                else        state_nxt_s = ST_IDLE;
            end
            ST_VSYNC: begin
                if (phase_r == VS_LAST) state_nxt_s = ST_VBACK;
                else                    state_nxt_s = ST_VSYNC;
            end
            ST_VBACK: begin
                if (phase_r == VB_LAST) state_nxt_s = ST_ACTIVE;
                else                    state_nxt_s = ST_VBACK;
            end
            ST_ACTIVE: begin
                if (phase_r == ACT_LAST) state_nxt_s = ST_HBLANK;
                else                     state_nxt_s = ST_ACTIVE;
            end
            ST_HBLANK: begin
                if (phase_r != HB_LAST) begin
                    state_nxt_s = ST_HBLANK;
                end else if (line_r == LN_LAST) begin
                    state_nxt_s = ST_VFRONT;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                    line_nxt_s  = line_r + LN_W'(1);
                end
            end
            ST_VFRONT: begin
                if (phase_r != VF_LAST) state_nxt_s = ST_VFRONT;
                else if (enable)        state_nxt_s = ST_VSYNC;
                else                    state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        if (state_nxt_s != state_r || state_r == ST_IDLE) begin
            phase_nxt_s = '0;
            byte_nxt_s  = 1'b0;
        end else begin
            phase_nxt_s = phase_r + PH_W'(1);
            byte_nxt_s  = (state_r == ST_ACTIVE) ? ~byte_r : 1'b0;
        end

        if (state_nxt_s == ST_VSYNC && state_r != ST_VSYNC) line_nxt_s = '0;
        else                                                line_nxt_s = line_nxt_s;

        // Fetch one cycle ahead of each high byte; the blank after the last line needs none.
        if (state_nxt_s == ST_VBACK && phase_nxt_s == VB_LAST)
            fetch_nxt_s = 1'b1;
        else if (state_nxt_s == ST_HBLANK && phase_nxt_s == HB_LAST && line_nxt_s != LN_LAST)
            fetch_nxt_s = 1'b1;
        else if (state_nxt_s == ST_ACTIVE && byte_nxt_s && phase_nxt_s != ACT_LAST)
            fetch_nxt_s = 1'b1;
        else
            fetch_nxt_s = 1'b0;

        if (pat_r)        pixel_s = pat_color_s;
        else if (s_valid) pixel_s = s_data;
        else              pixel_s = 16'h0000;
    end

    // FSM state, counters and all registered outputs.
    always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_r      <= ST_IDLE;
            phase_r      <= '0;
            line_r       <= '0;
            byte_r       <= 1'b0;
            fetch_r      <= 1'b0;
            pat_r        <= 1'b0;
            low_r        <= 8'h00;
            s_ready      <= 1'b0;
            ov5640_vsync <= 1'b0;
            ov5640_href  <= 1'b0;
            ov5640_data  <= 8'h00;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            phase_r      <= phase_nxt_s;
            line_r       <= line_nxt_s;
            byte_r       <= byte_nxt_s;
            fetch_r      <= fetch_nxt_s;
            s_ready      <= fetch_nxt_s && !pat_r;
            ov5640_vsync <= (state_nxt_s == ST_VSYNC);
            ov5640_href  <= (state_nxt_s == ST_ACTIVE);
            frame_done   <= (state_nxt_s == ST_VFRONT) && (phase_nxt_s == VF_LAST);

            // Mode and underrun are per-frame: both are (re)established on VSYNC entry.
            if (state_nxt_s == ST_VSYNC && state_r != ST_VSYNC) begin
                pat_r    <= pattern_sel_s;
                underrun <= 1'b0;
            end else if (fetch_r && !pat_r && !s_valid) begin
                pat_r    <= pat_r;
                underrun <= 1'b1;
            end else begin
                pat_r    <= pat_r;
                underrun <= underrun;
            end

            // High byte straight from the fetched pixel, low byte from the holding register.
            if (fetch_r) begin
                ov5640_data <= pixel_s[15:8];
                low_r       <= pixel_s[7:0];
            end else if (state_nxt_s == ST_ACTIVE) begin
                ov5640_data <= low_r;
                low_r       <= low_r;
            end else begin
                ov5640_data <= 8'h00;
                low_r       <= low_r;
            end
        end
    end

endmodule

// File: tb/tb_dvp_tx.sv
// tb_dvp_tx: self-checking bench for dvp_tx. A frame-position model (cycle
// offset -> line/pixel/byte by plain arithmetic) predicts every output on
// every cycle under directed and $urandom stimulus.
module tb_dvp_tx;

    localparam int H        = 8;
    localparam int VA       = 4;
    localparam int HB       = 4;
    localparam int VS       = 3;
    localparam int VB       = 5;
    localparam int VF       = 2;
    localparam int LINE_LEN = 2 * H + HB;
    localparam int ACT0     = VS + VB;
    localparam int FRAME    = ACT0 + VA * LINE_LEN + VF;
`ifdef DVP_TX_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        ov5640_pclk = 1'b0;
    logic        s_rst_n;
    logic        enable;
    logic        pattern_sel;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ov5640_vsync;
    logic        ov5640_href;
    logic [7:0]  ov5640_data;
    logic        frame_done;
    logic        underrun;

    dvp_tx #(
        .H_ACTIVE (H), .V_ACTIVE (VA), .H_BLANK (HB),
        .VSYNC_LEN(VS), .V_BACK (VB), .V_FRONT (VF)
    ) dut (
        .ov5640_pclk (ov5640_pclk),
        .s_rst_n     (s_rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .ov5640_vsync(ov5640_vsync),
        .ov5640_href (ov5640_href),
        .ov5640_data (ov5640_data),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 ov5640_pclk = ~ov5640_pclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    // model state
    bit          m_run     = 1'b0;
    int          m_k       = 0;
    bit          m_pat     = 1'b0;
    bit          m_under   = 1'b0;
    bit          m_fetched = 1'b0;
    logic [15:0] m_pix [VA*H];
    logic [15:0] pix_ctr;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Predict this cycle's outputs from the frame position, compare, then advance the model.
    task automatic model_step();
        logic        e_vs, e_href, e_rdy, e_done;
        logic [7:0]  e_data;
        logic [15:0] pv;
        bit          fetch;
        int          a, line, pos, pidx;
        e_vs = 1'b0; e_href = 1'b0; e_rdy = 1'b0; e_done = 1'b0; e_data = 8'h00;
        fetch = 1'b0; pidx = 0;
        if (!s_rst_n) begin
            m_run   = 1'b0;
            m_under = 1'b0;
        end else if (m_run) begin
            e_vs = (m_k < VS);
            a    = m_k - ACT0;
            if (a >= 0 && a < VA * LINE_LEN) begin
                line = a / LINE_LEN;
                pos  = a % LINE_LEN;
                if (pos < 2 * H) begin
                    e_href = 1'b1;
                    pv     = m_pix[line * H + pos / 2];
                    e_data = (pos % 2 == 0) ? pv[15:8] : pv[7:0];
                    if (pos % 2 == 1 && pos != 2 * H - 1) begin
                        fetch = 1'b1;
                        pidx  = line * H + pos / 2 + 1;
                    end
                end else if (pos == LINE_LEN - 1 && line < VA - 1) begin
                    fetch = 1'b1;
                    pidx  = (line + 1) * H;
                end
            end else if (m_k == ACT0 - 1) begin
                fetch = 1'b1;
                pidx  = 0;
            end
            e_rdy  = fetch && !m_pat;
            e_done = (m_k == FRAME - 1);
        end

        check_eq("vsync",      16'(ov5640_vsync), 16'(e_vs));
        check_eq("href",       16'(ov5640_href),  16'(e_href));
        check_eq("data",       16'(ov5640_data),  16'(e_data));
        check_eq("s_ready",    16'(s_ready),      16'(e_rdy));
        check_eq("frame_done", 16'(frame_done),   16'(e_done));
        check_eq("underrun",   16'(underrun),     16'(m_under));

        m_fetched = fetch && s_rst_n;
        if (s_rst_n) begin
            if (fetch) begin
                if (m_pat)        m_pix[pidx] = bars[(pidx % H) / (H / 8)];
                else if (s_valid) m_pix[pidx] = s_data;
                else begin
                    m_pix[pidx] = 16'h0000;
                    m_under     = 1'b1;
                end
            end
            if (m_run && m_k != FRAME - 1) begin
                m_k++;
            end else if (enable) begin
                m_run   = 1'b1;
                m_k     = 0;
                m_pat   = PAT_EN && pattern_sel;
                m_under = 1'b0;
            end else begin
                m_run = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge ov5640_pclk);
        model_step();
        cyc++;
        @(posedge ov5640_pclk);
        #1;
    endtask

    // Reset, then run ncyc cycles; negative cycle arguments disable that event.
    task automatic run_scn(input int ncyc, input int drop_en_at, input int inval_at,
                           input int rst_at, input bit rnd, input bit pat);
        s_rst_n = 1'b0; enable = 1'b0; pattern_sel = 1'b0; s_valid = 1'b0; s_data = 16'h0000;
        cyc = -2;
        tick();
        tick();
        pix_ctr = 16'h0102;
        for (int i = 0; i < ncyc; i++) begin
            s_rst_n = (i != rst_at);
            if (rnd) begin
                enable      = ($urandom_range(0, 19) != 0);
                pattern_sel = 1'($urandom_range(0, 1));
                s_valid     = ($urandom_range(0, 3) != 0);
                s_data      = 16'($urandom);
            end else begin
                enable      = (drop_en_at < 0 || i < drop_en_at);
                pattern_sel = pat;
                s_valid     = (i != inval_at) || pat;
                s_data      = pat ? 16'($urandom) : pix_ctr;
            end
            tick();
            if (m_fetched && s_valid) pix_ctr = pix_ctr + 16'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < VA * H; i++) m_pix[i] = 16'h0000;
        pix_ctr = 16'h0102;
        run_scn(2 * FRAME + 5, -1, -1, -1, 1'b0, 1'b0);  // back-to-back stream frames
        run_scn(FRAME + 10,    -1, 12, -1, 1'b0, 1'b0);  // missing pixel at cycle 12
        run_scn(2 * FRAME,     40, -1, -1, 1'b0, 1'b0);  // enable dropped mid-frame
        run_scn(FRAME + 5,     -1, -1, -1, 1'b0, 1'b1);  // colour bars
        run_scn(FRAME + 40,    -1, -1, 30, 1'b0, 1'b0);  // reset pulse mid-frame
        run_scn(8 * FRAME,     -1, -1, -1, 1'b1, 1'b0);  // random traffic
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
